// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - Debug Module DMI request/response types shared with the DM.
package dm;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_uart_pkg.sv
// rtl/dmi_uart_pkg.sv - Command ops, dmistat codes and sequencer states for the UART DMI bridge.
package dmi_uart_pkg;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_op_e;

  localparam logic [1:0] DMISTAT_OK     = 2'd0;
  localparam logic [1:0] DMISTAT_FAILED = 2'd2;
  localparam logic [1:0] DMISTAT_BUSY   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RESP,
    S_REPLY,
    S_HRST
  } seq_state_e;

  // DMI resp code 1 is reserved; it is reported as a plain failure.
  function automatic logic [1:0] resp_to_stat(input logic [1:0] resp);
    if (resp == 2'd0) return DMISTAT_OK;
    if (resp == 2'd3) return DMISTAT_BUSY;
    return DMISTAT_FAILED;
  endfunction

  function automatic logic [1:0] stat_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dmi_timeout_cnt.sv
// rtl/dmi_timeout_cnt.sv - Loadable down-counter that pulses expired_o when it has run out.
module dmi_timeout_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign expired_o = en_i && !load_i && (cnt_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmi_access_sequencer.sv
// rtl/dmi_access_sequencer.sv - Turns decoded UART commands into single DMI transactions and tracks dmistat.
module dmi_access_sequencer
  import dmi_uart_pkg::*;
#(
  parameter int unsigned ABITS       = 7,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned HRST_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [ABITS-1:0] cmd_addr_i,
  input  logic [31:0]      cmd_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [1:0]       rsp_status_o,
  input  logic             dmireset_i,
  input  logic             dmihardreset_i,
  output logic [1:0]       dmistat_o,
  output logic             busy_o,
  output logic             dmi_rst_no,
  output dm::dmi_req_t     dmi_req_o,
  output logic             dmi_req_valid_o,
  input  logic             dmi_req_ready_i,
  input  dm::dmi_resp_t    dmi_resp_i,
  input  logic             dmi_resp_valid_i,
  output logic             dmi_resp_ready_o
);

  localparam int unsigned CMAX  = (TIMEOUT > HRST_CYCLES) ? TIMEOUT : HRST_CYCLES;
  localparam int unsigned CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] HRST_LOAD = CNT_W'((HRST_CYCLES > 0) ? HRST_CYCLES - 1 : 0);

  seq_state_e   state_d, state_q;
  dm::dmi_req_t req_d, req_q;
  logic         req_valid_d, req_valid_q;
  logic         resp_ready_d, resp_ready_q;
  logic         rsp_valid_d, rsp_valid_q;
  logic [31:0]  rsp_data_d, rsp_data_q;
  logic [1:0]   rsp_status_d, rsp_status_q;
  logic [1:0]   dmistat_d, dmistat_q;
  logic         rst_n_d, rst_n_q;

  logic             cnt_load, cnt_en, cnt_expired;
  logic [CNT_W-1:0] cnt_val;
  logic             err_set;
  logic [1:0]       err_val, stat_base;
  logic             cmd_is_rw;

  dmi_timeout_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .expired_o  (cnt_expired)
  );

  assign cmd_is_rw = (cmd_op_i == CMD_READ) || (cmd_op_i == CMD_WRITE);

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_valid_d  = req_valid_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    rst_n_d      = 1'b1;
    cnt_load     = 1'b0;
    cnt_val      = TO_LOAD;
    cnt_en       = 1'b0;
    err_set      = 1'b0;
    err_val      = DMISTAT_OK;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_is_rw && (dmistat_q == DMISTAT_OK)) begin
            req_d.addr  = 7'(cmd_addr_i);
            req_d.op    = (cmd_op_i == CMD_READ) ? dm::DTM_READ : dm::DTM_WRITE;
            req_d.data  = (cmd_op_i == CMD_WRITE) ? cmd_data_i : 32'd0;
            req_valid_d = 1'b1;
            cnt_load    = 1'b1;
            state_d     = S_REQ;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = 32'd0;
            rsp_status_d = dmistat_q;
            state_d      = S_REPLY;
          end
        end
      end
      S_REQ: begin
        cnt_en = (TIMEOUT != 0);
        if (cnt_expired) begin
          req_valid_d  = 1'b0;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = 32'd0;
          rsp_status_d = DMISTAT_BUSY;
          err_set      = 1'b1;
          err_val      = DMISTAT_BUSY;
          state_d      = S_REPLY;
        end else if (dmi_req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        cnt_en = (TIMEOUT != 0);
        if (dmi_resp_valid_i) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = (req_q.op == dm::DTM_READ) ? dmi_resp_i.data : 32'd0;
          rsp_status_d = resp_to_stat(dmi_resp_i.resp);
          err_set      = (dmi_resp_i.resp != 2'd0);
          err_val      = resp_to_stat(dmi_resp_i.resp);
          state_d      = S_REPLY;
        end else if (cnt_expired) begin
          rsp_valid_d  = 1'b1;
          rsp_data_d   = 32'd0;
          rsp_status_d = DMISTAT_BUSY;
          err_set      = 1'b1;
          err_val      = DMISTAT_BUSY;
          state_d      = S_REPLY;
        end
      end
      S_REPLY: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      S_HRST: begin
        cnt_en  = 1'b1;
        rst_n_d = 1'b0;
        if (cnt_expired) begin
          rst_n_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new error set in the same cycle as dmireset_i survives the clear.
    stat_base = dmireset_i ? DMISTAT_OK : dmistat_q;
    dmistat_d = err_set ? stat_max(stat_base, err_val) : stat_base;

    if (dmihardreset_i) begin
      state_d     = S_HRST;
      req_valid_d = 1'b0;
      rsp_valid_d = 1'b0;
      rst_n_d     = 1'b0;
      dmistat_d   = DMISTAT_OK;
      cnt_load    = 1'b1;
      cnt_val     = HRST_LOAD;
      cnt_en      = 1'b0;
    end

    // Late responses from a timed-out transaction are drained while idle.
    resp_ready_d = (state_d == S_IDLE) || (state_d == S_WAIT_RESP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_status_q <= DMISTAT_OK;
      dmistat_q    <= DMISTAT_OK;
      rst_n_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      dmistat_q    <= dmistat_d;
      rst_n_q      <= rst_n_d;
    end
  end

  assign cmd_ready_o      = (state_q == S_IDLE) && !dmihardreset_i;
  assign busy_o           = (state_q != S_IDLE);
  assign dmi_req_o        = req_q;
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_status_o     = rsp_status_q;
  assign dmistat_o        = dmistat_q;
  assign dmi_rst_no       = rst_n_q;

endmodule

// File: tb/tb_dmi_access_sequencer.sv
// tb/tb_dmi_access_sequencer.sv - Self-checking bench for dmi_access_sequencer with a DM responder and reference model.
module tb_dmi_access_sequencer;
  import dm::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'd0;
  logic [6:0]  cmd_addr_i = 7'd0;
  logic [31:0] cmd_data_i = 32'd0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_status_o, dmistat_o;
  logic        dmireset_i = 1'b0, dmihardreset_i = 1'b0;
  logic        busy_o, dmi_rst_no;
  dmi_req_t    dmi_req_o;
  logic        dmi_req_valid_o, dmi_req_ready_i = 1'b0;
  dmi_resp_t   dmi_resp_i = '0;
  logic        dmi_resp_valid_i = 1'b0, dmi_resp_ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  dmi_access_sequencer #(.ABITS(7), .TIMEOUT(16), .HRST_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .rsp_status_o(rsp_status_o), .dmireset_i(dmireset_i), .dmihardreset_i(dmihardreset_i),
    .dmistat_o(dmistat_o), .busy_o(busy_o), .dmi_rst_no(dmi_rst_no),
    .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  // Observations from the most recent run_cmd call.
  bit          r_ok, r_req_seen, r_req_stable, r_rsp_stable, r_rdy_busy;
  dmi_req_t    r_req;
  logic [31:0] r_data;
  logic [1:0]  r_status;
  int          r_hs, r_first_req, r_first_rsp, r_resp_cyc, r_req_cycles, r_hold;

  // Plays both decoder and DM for one command; all events are sampled and driven on negedges.
  task automatic run_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                         input int req_dly, input int resp_dly, input logic [31:0] rdata,
                         input logic [1:0] rcode, input bit respond, input int hold);
    int  req_wait, resp_wait, hold_cnt;
    bit  pend, accepted;
    r_ok = 0; r_req_seen = 0; r_req_stable = 1; r_rsp_stable = 1; r_rdy_busy = 0;
    r_req = '0; r_data = '0; r_status = '0; r_hs = 0; r_first_req = -1; r_first_rsp = -1;
    r_resp_cyc = -1; r_req_cycles = 0; r_hold = 0;
    req_wait = 0; resp_wait = 0; hold_cnt = 0; pend = 0; accepted = 0;
    @(negedge clk_i);
    cmd_valid_i = 1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = wdata;
    for (int i = 0; i < 50 && !accepted; i++) begin
      if (cmd_ready_o) accepted = 1;
      @(negedge clk_i);
    end
    cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = 0; cmd_data_i = 0;
    if (!accepted) return;
    for (int cyc = 0; cyc < 300; cyc++) begin
      dmi_req_ready_i = 0; dmi_resp_valid_i = 0; rsp_ready_i = 0;
      if (rsp_valid_o) begin
        if (r_first_rsp < 0) begin
          r_first_rsp = cyc; r_data = rsp_data_o; r_status = rsp_status_o;
        end else if (rsp_data_o !== r_data || rsp_status_o !== r_status) r_rsp_stable = 0;
        if (cmd_ready_o) r_rdy_busy = 1;
        if (hold_cnt >= hold) rsp_ready_i = 1;
        hold_cnt++;
      end
      if (dmi_req_valid_o) begin
        r_req_cycles++;
        if (cmd_ready_o) r_rdy_busy = 1;
        if (r_first_req < 0) begin
          r_first_req = cyc; r_req = dmi_req_o; r_req_seen = 1;
        end else if (dmi_req_o !== r_req) r_req_stable = 0;
        if (req_wait >= req_dly) begin
          dmi_req_ready_i = 1; r_hs++; pend = respond;
        end
        req_wait++;
      end else if (pend && dmi_resp_ready_o) begin
        if (resp_wait >= resp_dly) begin
          dmi_resp_valid_i = 1; dmi_resp_i = '{data: rdata, resp: rcode};
          pend = 0; r_resp_cyc = cyc;
        end
        resp_wait++;
      end
      @(negedge clk_i);
      if (rsp_ready_i) begin
        r_ok = 1;
        break;
      end
    end
    dmi_req_ready_i = 0; dmi_resp_valid_i = 0; rsp_ready_i = 0; dmi_resp_i = '0;
    r_hold = hold_cnt;
  endtask

  task automatic pulse_dmireset();
    @(negedge clk_i); dmireset_i = 1;
    @(negedge clk_i); dmireset_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    #12;
    n_tests++; if (cmd_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready_o); end
    n_tests++; if ({rsp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, busy_o} !== 4'b0) begin n_fail++; $display("FAIL reset_valids got %b exp 0000", {rsp_valid_o, dmi_req_valid_o, dmi_resp_ready_o, busy_o}); end
    n_tests++; if ({dmistat_o, dmi_rst_no} !== 3'b001) begin n_fail++; $display("FAIL reset_stat_rst got %b exp 001", {dmistat_o, dmi_rst_no}); end
    n_tests++; if ({dmi_req_o, rsp_data_o, rsp_status_o} !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {dmi_req_o, rsp_data_o, rsp_status_o}); end
    @(negedge clk_i); rst_ni = 1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_read_basic();
    run_cmd(2'd1, 7'h11, 32'h5555_AAAA, 0, 0, 32'hDEADBEEF, 2'd0, 1, 0);
    n_tests++; if (!r_ok) begin n_fail++; $display("FAIL read_done got %b exp 1", r_ok); end
    n_tests++; if (r_req.op !== DTM_READ || r_req.addr !== 7'h11 || r_req.data !== 32'd0) begin n_fail++; $display("FAIL read_req got %h exp op=1 addr=11 data=0", r_req); end
    n_tests++; if (r_data !== 32'hDEADBEEF || r_status !== 2'd0) begin n_fail++; $display("FAIL read_rsp got %h/%0d exp deadbeef/0", r_data, r_status); end
    n_tests++; if (r_first_req !== 0 || r_first_rsp !== r_resp_cyc + 1) begin n_fail++; $display("FAIL read_latency got req=%0d rsp=%0d resp=%0d exp 0,resp+1", r_first_req, r_first_rsp, r_resp_cyc); end
    n_tests++; if (dmistat_o !== 2'd0 || r_hs !== 1) begin n_fail++; $display("FAIL read_stat got %0d hs=%0d exp 0 hs=1", dmistat_o, r_hs); end
  endtask

  task automatic test_write_stall();
    run_cmd(2'd2, 7'h10, 32'h1, 5, 1, 32'hFFFF_FFFF, 2'd0, 1, 0);
    n_tests++; if (!r_ok || !r_req_stable || r_req_cycles !== 6) begin n_fail++; $display("FAIL write_stall got ok=%b stable=%b cycles=%0d exp 1,1,6", r_ok, r_req_stable, r_req_cycles); end
    n_tests++; if (r_hs !== 1 || r_req.op !== DTM_WRITE || r_req.addr !== 7'h10 || r_req.data !== 32'h1) begin n_fail++; $display("FAIL write_req got hs=%0d req=%h exp hs=1 write 10 1", r_hs, r_req); end
    n_tests++; if (r_data !== 32'd0 || r_status !== 2'd0) begin n_fail++; $display("FAIL write_rsp got %h/%0d exp 0/0", r_data, r_status); end
  endtask

  task automatic test_sticky_busy();
    logic [31:0] d;
    run_cmd(2'd1, 7'h04, 32'h0, 0, 2, 32'h1234_5678, 2'd3, 1, 0);
    n_tests++; if (r_status !== 2'd3 || dmistat_o !== 2'd3) begin n_fail++; $display("FAIL busy_resp got status=%0d dmistat=%0d exp 3/3", r_status, dmistat_o); end
    run_cmd(2'd2, 7'h04, 32'h99, 0, 0, 32'h0, 2'd0, 1, 0);
    n_tests++; if (!r_ok || r_req_seen || r_status !== 2'd3 || r_data !== 32'd0) begin n_fail++; $display("FAIL busy_reject got ok=%b req=%b status=%0d data=%h exp 1,0,3,0", r_ok, r_req_seen, r_status, r_data); end
    pulse_dmireset();
    n_tests++; if (dmistat_o !== 2'd0) begin n_fail++; $display("FAIL dmireset got %0d exp 0", dmistat_o); end
    d = $urandom;
    run_cmd(2'd1, 7'h04, 32'h0, 1, 0, d, 2'd0, 1, 0);
    n_tests++; if (r_status !== 2'd0 || r_data !== d || r_hs !== 1) begin n_fail++; $display("FAIL after_reset_read got %0d/%h hs=%0d exp 0/%h hs=1", r_status, r_data, r_hs, d); end
  endtask

  task automatic test_timeout();
    bit saw;
    run_cmd(2'd1, 7'h22, 32'h0, 0, 0, 32'h0, 2'd0, 0, 0);
    n_tests++; if (!r_ok || r_status !== 2'd3 || r_data !== 32'd0 || r_first_rsp - r_first_req !== 16) begin n_fail++; $display("FAIL timeout_wait got ok=%b st=%0d lat=%0d exp 1,3,16", r_ok, r_status, r_first_rsp - r_first_req); end
    n_tests++; if (dmistat_o !== 2'd3) begin n_fail++; $display("FAIL timeout_stat got %0d exp 3", dmistat_o); end
    pulse_dmireset();
    run_cmd(2'd2, 7'h23, 32'h77, 100, 0, 32'h0, 2'd0, 1, 0);
    n_tests++; if (r_hs !== 0 || r_req_cycles !== 16 || r_status !== 2'd3 || r_first_rsp - r_first_req !== 16) begin n_fail++; $display("FAIL timeout_req got hs=%0d cyc=%0d st=%0d lat=%0d exp 0,16,3,16", r_hs, r_req_cycles, r_status, r_first_rsp - r_first_req); end
    @(negedge clk_i);
    n_tests++; if (dmi_resp_ready_o !== 1'b1 || dmi_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_drain_ready got %b/%b exp 1/0", dmi_resp_ready_o, dmi_req_valid_o); end
    dmi_resp_valid_i = 1; dmi_resp_i = '{data: 32'hBAD0_BAD0, resp: 2'd0};
    @(negedge clk_i); dmi_resp_valid_i = 0; dmi_resp_i = '0;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid_o || busy_o) saw = 1;
      @(negedge clk_i);
    end
    n_tests++; if (saw) begin n_fail++; $display("FAIL late_resp_dropped got activity=1 exp 0"); end
    pulse_dmireset();
  endtask

  task automatic test_hardreset();
    int low;
    bit saw;
    @(negedge clk_i);
    cmd_valid_i = 1; cmd_op_i = 2'd1; cmd_addr_i = 7'h05;
    @(negedge clk_i);
    cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = 0;
    dmi_req_ready_i = dmi_req_valid_o;
    @(negedge clk_i);
    dmi_req_ready_i = 0;
    n_tests++; if (dmi_resp_ready_o !== 1'b1 || busy_o !== 1'b1) begin n_fail++; $display("FAIL hrst_pre_wait got ready=%b busy=%b exp 1,1", dmi_resp_ready_o, busy_o); end
    repeat (2) @(negedge clk_i);
    dmihardreset_i = 1;
    @(negedge clk_i);
    dmihardreset_i = 0;
    low = 0; saw = 0;
    for (int i = 0; i < 12; i++) begin
      if (!dmi_rst_no) low++;
      if (rsp_valid_o || dmi_req_valid_o) saw = 1;
      @(negedge clk_i);
    end
    n_tests++; if (low !== 4 || saw) begin n_fail++; $display("FAIL hrst_pulse got low=%0d valid=%b exp 4,0", low, saw); end
    n_tests++; if (cmd_ready_o !== 1'b1 || dmistat_o !== 2'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL hrst_after got rdy=%b stat=%0d busy=%b exp 1,0,0", cmd_ready_o, dmistat_o, busy_o); end
  endtask

  task automatic test_nop_hold();
    run_cmd(2'd0, 7'h3F, 32'hFFFF_FFFF, 0, 0, 32'h0, 2'd0, 1, 10);
    n_tests++; if (!r_ok || r_first_rsp !== 0 || r_hold !== 11 || !r_rsp_stable) begin n_fail++; $display("FAIL nop_hold got ok=%b first=%0d hold=%0d stable=%b exp 1,0,11,1", r_ok, r_first_rsp, r_hold, r_rsp_stable); end
    n_tests++; if (r_rdy_busy || r_req_seen || r_data !== 32'd0 || r_status !== 2'd0) begin n_fail++; $display("FAIL nop_quiet got rdy=%b req=%b data=%h st=%0d exp 0,0,0,0", r_rdy_busy, r_req_seen, r_data, r_status); end
  endtask

  task automatic test_random();
    int model_stat, exp_stat, rc_stat, errs;
    logic [1:0] op, rc;
    logic [6:0] addr;
    logic [31:0] wdata, rdata, exp_data;
    bit issue;
    model_stat = 0; errs = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        pulse_dmireset();
        model_stat = 0;
      end
      op = 2'($urandom_range(0, 3)); addr = 7'($urandom); wdata = $urandom; rdata = $urandom;
      case ($urandom_range(0, 5))
        4: rc = 2'd2;
        5: rc = 2'd3;
        default: rc = 2'd0;
      endcase
      run_cmd(op, addr, wdata, $urandom_range(0, 3), $urandom_range(0, 3), rdata, rc, 1, $urandom_range(0, 2));
      rc_stat  = (rc == 2'd0) ? 0 : (rc == 2'd3) ? 3 : 2;
      issue    = (op == 2'd1 || op == 2'd2) && model_stat == 0;
      exp_stat = issue ? rc_stat : model_stat;
      exp_data = (issue && op == 2'd1) ? rdata : 32'd0;
      if (issue && rc_stat > model_stat) model_stat = rc_stat;
      n_tests++;
      if (!r_ok || r_status !== 2'(exp_stat) || r_data !== exp_data || r_hs !== (issue ? 1 : 0) || dmistat_o !== 2'(model_stat)) begin
        n_fail++; errs++;
        $display("FAIL rand_%0d got ok=%b st=%0d data=%h hs=%0d stat=%0d exp st=%0d data=%h hs=%0d stat=%0d", it, r_ok, r_status, r_data, r_hs, dmistat_o, exp_stat, exp_data, issue ? 1 : 0, model_stat);
      end
      if (issue) begin
        n_tests++;
        if (r_req.addr !== addr || r_req.op !== dtm_op_e'(op) || r_req.data !== ((op == 2'd2) ? wdata : 32'd0)) begin
          n_fail++;
          $display("FAIL rand_req_%0d got %h exp addr=%h op=%0d wdata=%h", it, r_req, addr, op, wdata);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk_i);
    cmd_valid_i = 1; cmd_op_i = 2'd2; cmd_addr_i = 7'h33; cmd_data_i = 32'hCAFE;
    @(negedge clk_i);
    cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = 0; cmd_data_i = 0;
    n_tests++; if (dmi_req_valid_o !== 1'b1) begin n_fail++; $display("FAIL async_pre got %b exp 1", dmi_req_valid_o); end
    #2 rst_ni = 0;
    #1;
    n_tests++; if (dmi_req_valid_o !== 1'b0 || dmi_req_o !== '0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL async_reset got v=%b req=%h rdy=%b busy=%b exp 0,0,1,0", dmi_req_valid_o, dmi_req_o, cmd_ready_o, busy_o); end
    @(negedge clk_i); rst_ni = 1;
    @(negedge clk_i);
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_sticky_busy();
    test_timeout();
    test_hardreset();
    test_nop_hold();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
